uart_frame_encoder: RTL

Parametrised successor of the single-channel card encoder. Serialises the status flags and card-value slots of up to 4 channels (dealer plus players) into framed bytes for the UART TX FIFO, throttled by tx_full. Each frame is built from a snapshot of the inputs, so a frame is always self-consistent. Sits between the game FSM/card store and uart_tx FIFO write port.

---
 rtl/uart_enc_pkg.sv | 51 +++++
 rtl/uart_enc_trigger.sv | 55 +++++
 rtl/uart_frame_encoder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_enc_pkg.sv
// Shared types and byte builders for the UART frame encoder.
// UART_ENC_CHECKSUM_EN adds the trailing XOR checksum byte.
package uart_enc_pkg;

    localparam int MAX_CH    = 4;
    localparam int MAX_SLOTS = 15;
    localparam int MAX_GAP   = 255;

    // Index nibble 0 always identifies a channel header byte.
    localparam logic [3:0] HDR_IDX = 4'h0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SNAP = 3'd1,
        ST_HDR  = 3'd2,
        ST_SLOT = 3'd3,
`ifdef UART_ENC_CHECKSUM_EN
        ST_CSUM = 3'd4,
`endif
        ST_GAP  = 3'd5
    } enc_state_t;

    function automatic logic [7:0] hdr_byte(
        input logic [1:0] ch,
        input logic       deal,
        input logic       fin
    );
        return {ch, deal, fin, HDR_IDX};
    endfunction

    // Slot indices go out 1-based so they never collide with HDR_IDX.
    function automatic logic [7:0] slot_byte(
        input logic [3:0] val,
        input logic [3:0] slot
    );
        return {val, slot + 4'd1};
    endfunction

    function automatic bit cfg_ok(
        input int nch,
        input int nslots,
        input int mode,
        input int gap
    );
        return (nch >= 1) && (nch <= MAX_CH) &&
               (nslots >= 1) && (nslots <= MAX_SLOTS) &&
               (mode >= 0) && (mode <= 2) &&
               (gap >= 0) && (gap <= MAX_GAP);
    endfunction

endpackage

// File: rtl/uart_enc_trigger.sv
// Frame trigger detection and input snapshot register.
// The snapshot keeps each frame self-consistent while inputs move.
module uart_enc_trigger
    import uart_enc_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int NUM_SLOTS = 9,
    parameter int TRIG_MODE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        idle,
    input  logic                        snap_en,
    input  logic                        start,
    input  logic [NUM_CH-1:0]           deal,
    input  logic [NUM_CH-1:0]           finished,
    input  logic [NUM_CH*NUM_SLOTS*4-1:0] card_values,
    output logic                        trig,
    output logic [NUM_CH-1:0]           deal_s,
    output logic [NUM_CH-1:0]           finished_s,
    output logic [NUM_CH*NUM_SLOTS*4-1:0] card_s
);

    localparam int SW = NUM_CH * (2 + 4 * NUM_SLOTS);

    logic [SW-1:0] live;
    logic [SW-1:0] snap_q;

    assign live = {deal, finished, card_values};
    assign {deal_s, finished_s, card_s} = snap_q;

    // Capture all inputs in the single SNAP cycle of each frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q <= '0;
        end else if (snap_en) begin
            snap_q <= live;
        end
    end

    // Trigger only counts while idle, so requests during a frame drop.
    always_comb begin
        trig = 1'b0;
        if (idle) begin
            if (TRIG_MODE == 0) begin
                trig = start;
            end else if (TRIG_MODE == 1) begin
                trig = 1'b1;
            end else begin
                trig = start || (live != snap_q);
            end
        end
    end

endmodule

// File: rtl/uart_frame_encoder.sv
// Serialises channel flags and card slots into framed UART bytes.
// UART_ENC_CHECKSUM_EN appends an XOR checksum byte per frame.
module uart_frame_encoder
    import uart_enc_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int NUM_SLOTS  = 9,
    parameter int TRIG_MODE  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tx_full,
    input  logic                        start,
    input  logic [NUM_CH-1:0]           deal,
    input  logic [NUM_CH-1:0]           finished,
    input  logic [NUM_CH*NUM_SLOTS*4-1:0] card_values,
    output logic                        wr_uart,
    output logic [7:0]                  w_data,
    output logic                        busy,
    output logic                        frame_done
);

    localparam logic [1:0] LAST_CH   = 2'(NUM_CH - 1);
    localparam logic [3:0] LAST_SLOT = 4'(NUM_SLOTS - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
    localparam enc_state_t END_ST    =
        (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    if (!cfg_ok(NUM_CH, NUM_SLOTS, TRIG_MODE, GAP_CYCLES))
    begin : g_bad_cfg
        $error("uart_frame_encoder: parameter out of range");
    end

    enc_state_t state_q, state_d;
    logic [1:0] ch_q, ch_d;
    logic [3:0] slot_q, slot_d;
    logic [7:0] gap_q, gap_d;
    logic       wr_q;
    logic [7:0] wdata_q;
    logic       last_q;
    logic       done_q;

    logic       trig;
    logic       issue;
    logic       final_issue;
    logic       can_wr;
    logic [7:0] cur_byte;
    logic       hdr_deal;
    logic       hdr_fin;
    logic [3:0] slot_val;

    logic [NUM_CH-1:0]           deal_s;
    logic [NUM_CH-1:0]           finished_s;
    logic [NUM_CH*NUM_SLOTS*4-1:0] card_s;

`ifdef UART_ENC_CHECKSUM_EN
    logic [7:0] csum_q;
`endif

    uart_enc_trigger #(
        .NUM_CH    (NUM_CH),
        .NUM_SLOTS (NUM_SLOTS),
        .TRIG_MODE (TRIG_MODE)
    ) u_trig (
        .clk         (clk),
        .rst         (rst),
        .idle        (state_q == ST_IDLE),
        .snap_en     (state_q == ST_SNAP),
        .start       (start),
        .deal        (deal),
        .finished    (finished),
        .card_values (card_values),
        .trig        (trig),
        .deal_s      (deal_s),
        .finished_s  (finished_s),
        .card_s      (card_s)
    );

    // Pick the snapshot fields addressed by the current channel/slot.
    always_comb begin
        hdr_deal = 1'b0;
        hdr_fin  = 1'b0;
        slot_val = 4'h0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == 2'(c)) begin
                hdr_deal = deal_s[c];
                hdr_fin  = finished_s[c];
                for (int s = 0; s < NUM_SLOTS; s++) begin
                    if (slot_q == 4'(s)) begin
                        slot_val = card_s[(c*NUM_SLOTS+s)*4 +: 4];
                    end
                end
            end
        end
    end

    // Byte mux for the byte that would be written this cycle.
    always_comb begin
        cur_byte = 8'h00;
        unique case (1'b1)
            (state_q == ST_HDR):
                cur_byte = hdr_byte(ch_q, hdr_deal, hdr_fin);
            (state_q == ST_SLOT):
                cur_byte = slot_byte(slot_val, slot_q);
`ifdef UART_ENC_CHECKSUM_EN
            (state_q == ST_CSUM):
                cur_byte = csum_q;
`endif
            default:
                cur_byte = 8'h00;
        endcase
    end

    // A write in the previous cycle blocks this one so that
    // tx_full is always re-sampled between two writes.
    assign can_wr = !tx_full && !wr_q;

    // Next-state, index advance and write-issue decisions.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        slot_d      = slot_q;
        gap_d       = gap_q;
        issue       = 1'b0;
        final_issue = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_SNAP;
                end
            end
            ST_SNAP: begin
                ch_d    = 2'd0;
                slot_d  = 4'd0;
                state_d = ST_HDR;
            end
            ST_HDR: begin
                if (can_wr) begin
                    issue   = 1'b1;
                    slot_d  = 4'd0;
                    state_d = ST_SLOT;
                end
            end
            ST_SLOT: begin
                if (can_wr) begin
                    issue = 1'b1;
                    if (slot_q != LAST_SLOT) begin
                        slot_d = slot_q + 4'd1;
                    end else if (ch_q != LAST_CH) begin
                        slot_d  = 4'd0;
                        ch_d    = ch_q + 2'd1;
                        state_d = ST_HDR;
                    end else begin
                        slot_d = 4'd0;
`ifdef UART_ENC_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        final_issue = 1'b1;
                        state_d     = END_ST;
`endif
                    end
                end
            end
`ifdef UART_ENC_CHECKSUM_EN
            ST_CSUM: begin
                if (can_wr) begin
                    issue       = 1'b1;
                    final_issue = 1'b1;
                    state_d     = END_ST;
                end
            end
`endif
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (final_issue) begin
            gap_d = 8'd0;
        end
    end

    // State, indices and registered FIFO write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ch_q    <= 2'd0;
            slot_q  <= 4'd0;
            gap_q   <= 8'd0;
            wr_q    <= 1'b0;
            wdata_q <= 8'h00;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            slot_q  <= slot_d;
            gap_q   <= gap_d;
            wr_q    <= issue;
            if (issue) begin
                wdata_q <= cur_byte;
            end
            last_q  <= final_issue;
            done_q  <= last_q;
        end
    end

`ifdef UART_ENC_CHECKSUM_EN
    // Running XOR of every byte written in the current frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= 8'h00;
        end else if (state_q == ST_SNAP) begin
            csum_q <= 8'h00;
        end else if (issue) begin
            csum_q <= csum_q ^ cur_byte;
        end
    end
`endif

    assign wr_uart    = wr_q;
    assign w_data     = wdata_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;

endmodule
